// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each requester has a one-entry result register that holds its last result until it is consumed.
module alu_arbiter #(
    parameter int unsigned PRIORITY_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_x,
    input  logic [63:0] req_y,
    input  logic [5:0]  req_op,
    input  logic [11:0] req_shamt,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_out,
    output logic [3:0]  rsp_flag,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_op,
    output logic [5:0]  alu_shamt,
    output logic [31:0] alu_flag,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_nflag
);

    logic       prio;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       unused_nflag_hi;

    assign unused_nflag_hi = ^alu_nflag[31:2];

    // A requester may issue when its result slot is empty or being drained this cycle.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant = '0;
        if (rst_n) begin
            unique case (eligible)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;
    assign alu_flag  = '0;

    always_comb begin
        alu_x     = '0;
        alu_y     = '0;
        alu_op    = '0;
        alu_shamt = '0;
        if (grant[0]) begin
            alu_x     = req_x[31:0];
            alu_y     = req_y[31:0];
            alu_op    = req_op[2:0];
            alu_shamt = req_shamt[5:0];
        end else if (grant[1]) begin
            alu_x     = req_x[63:32];
            alu_y     = req_y[63:32];
            alu_op    = req_op[5:3];
            alu_shamt = req_shamt[11:6];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_out   <= '0;
            rsp_flag  <= '0;
            prio      <= (PRIORITY_INIT != 0);
        end else begin
            // A grant wins over a consume so a slot can turn over one result per cycle.
            for (int unsigned i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_valid[i]        <= 1'b1;
                    rsp_out[32*i +: 32] <= alu_out;
                    rsp_flag[2*i +: 2]  <= alu_nflag[1:0];
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
            if (|grant) begin
                prio <= grant[0];
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a bench-side ALU, a transaction-level reference model
// compared on every falling edge, and directed scenarios with literal expectations.
module tb_alu_arbiter;

    localparam int unsigned PINIT = 0;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_x;
    logic [63:0] req_y;
    logic [5:0]  req_op;
    logic [11:0] req_shamt;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_out;
    logic [3:0]  rsp_flag;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [2:0]  alu_op;
    logic [5:0]  alu_shamt;
    logic [31:0] alu_flag;
    logic [31:0] alu_out;
    logic [31:0] alu_nflag;
    logic [33:0] alu_res;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIORITY_INIT(PINIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_op    (req_op),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_flag  (rsp_flag),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_op    (alu_op),
        .alu_shamt (alu_shamt),
        .alu_flag  (alu_flag),
        .alu_out   (alu_out),
        .alu_nflag (alu_nflag)
    );

    // Returns {zero, overflow, result}.
    function automatic logic [33:0] alu_calc(input logic [2:0] op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [5:0] sh);
        logic [31:0] r;
        logic        ovf;
        r   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin r = x + y; ovf = (x[31] == y[31]) && (r[31] != x[31]); end
            OP_SUB: begin r = x - y; ovf = (x[31] != y[31]) && (r[31] != x[31]); end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_SLL: r = x << sh[4:0];
            OP_SRL: r = x >> sh[4:0];
            default: r = {31'b0, ($signed(x) < $signed(y))};
        endcase
        return {(r == 32'd0), ovf, r};
    endfunction

    // Shared ALU; upper NFlag bits carry junk that must never reach rsp_flag.
    assign alu_res   = alu_calc(alu_op, alu_x, alu_y, alu_shamt);
    assign alu_out   = alu_res[31:0];
    assign alu_nflag = {30'h2AAAAAAA, alu_res[33:32]};

    // Which requester is served this cycle, or -1.
    function automatic int pick(input logic [1:0] v, input logic [1:0] held, input logic [1:0] rr,
                                input int ptr, input logic run);
        logic e0, e1;
        e0 = v[0] && (!held[0] || rr[0]);
        e1 = v[1] && (!held[1] || rr[1]);
        if (!run) return -1;
        if (e0 && e1) return ptr;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    bit          m_live = 1'b0;
    logic [1:0]  m_valid;
    logic [31:0] m_out [2];
    logic [1:0]  m_flag [2];
    int          m_ptr;

    always @(posedge clk) begin
        int g;
        logic [33:0] r;
        if (!rst_n) begin
            m_live  = 1'b1;
            m_valid = '0;
            m_out[0] = '0; m_out[1] = '0;
            m_flag[0] = '0; m_flag[1] = '0;
            m_ptr = int'(PINIT);
        end else if (m_live) begin
            g = pick(req_valid, m_valid, rsp_ready, m_ptr, 1'b1);
            for (int i = 0; i < 2; i++) begin
                if (g == i) begin
                    r = alu_calc(req_op[3*i +: 3], req_x[32*i +: 32], req_y[32*i +: 32],
                                 req_shamt[6*i +: 6]);
                    m_valid[i] = 1'b1;
                    m_out[i]   = r[31:0];
                    m_flag[i]  = r[33:32];
                end else if (rsp_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (g >= 0) m_ptr = 1 - g;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int g;
        logic [1:0]  er;
        logic [31:0] ex, ey;
        logic [2:0]  eo;
        logic [5:0]  es;
        if (m_live) begin
            g  = pick(req_valid, m_valid, rsp_ready, m_ptr, rst_n);
            er = '0; ex = '0; ey = '0; eo = '0; es = '0;
            if (g >= 0) begin
                er[g] = 1'b1;
                ex = req_x[32*g +: 32];
                ey = req_y[32*g +: 32];
                eo = req_op[3*g +: 3];
                es = req_shamt[6*g +: 6];
            end
            chk("req_ready", req_ready, er);
            chk("alu_x", alu_x, ex);
            chk("alu_y", alu_y, ey);
            chk("alu_op", alu_op, eo);
            chk("alu_shamt", alu_shamt, es);
            chk("alu_flag", alu_flag, 0);
            chk("rsp_valid", rsp_valid, m_valid);
            chk("rsp_out", rsp_out, {m_out[1], m_out[0]});
            chk("rsp_flag", rsp_flag, {m_flag[1], m_flag[0]});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [5:0] sh);
        req_op[3*i +: 3]    = op;
        req_x[32*i +: 32]   = x;
        req_y[32*i +: 32]   = y;
        req_shamt[6*i +: 6] = sh;
    endtask

    logic [31:0] exp40 [3] = '{32'd6, 32'd5, 32'd4};
    logic [31:0] exp41 [4] = '{32'd7, 32'd17, 32'd27, 32'd37};
    logic [1:0]  vtab  [8] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b10};
    logic [1:0]  rtab  [8] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b11};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_x = '0; req_y = '0; req_op = '0; req_shamt = '0;
        tick; tick;

        // Held in reset with requests pending: nothing granted, ALU drive quiet.
        req_valid = 2'b11;
        set_req(0, OP_OR, 32'h55, 32'h1, 6'd3);
        @(negedge clk);
        chk("lit_rst_ready", req_ready, 2'b00);
        chk("lit_rst_alu_x", alu_x, 0);
        chk("lit_rst_rsp_valid", rsp_valid, 2'b00);
        tick;

        // Zero flag.
        rst_n = 1'b1; req_valid = 2'b01; rsp_ready = 2'b11;
        set_req(0, OP_SUB, 32'd300, 32'd300, 6'd0);
        @(negedge clk);
        chk("lit_zero_grant", req_ready, 2'b01);
        tick;
        req_valid = 2'b00;
        @(negedge clk);
        chk("lit_zero_valid", rsp_valid[0], 1);
        chk("lit_zero_out", rsp_out[31:0], 0);
        chk("lit_zero_flag", rsp_flag[1:0], 2'b10);
        tick;

        // Overflow.
        req_valid = 2'b10;
        set_req(1, OP_ADD, 32'h7fffffff, 32'd1, 6'd0);
        tick;
        req_valid = 2'b00;
        @(negedge clk);
        chk("lit_ovf_out", rsp_out[63:32], 32'h80000000);
        chk("lit_ovf_flag", rsp_flag[3:2], 2'b01);
        tick;

        // Contention right after reset.
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        set_req(0, OP_ADD, 32'd100, 32'd200, 6'd0);
        set_req(1, OP_AND, 32'd100, 32'd200, 6'd0);
        @(negedge clk);
        chk("lit_cont_grant0", req_ready, 2'b01);
        tick;
        @(negedge clk);
        chk("lit_cont_grant1", req_ready, 2'b10);
        chk("lit_cont_out0", rsp_out[31:0], 32'd300);
        tick;
        req_valid = 2'b00;
        @(negedge clk);
        chk("lit_cont_out1", rsp_out[63:32], 32'd64);
        tick;

        // Backpressure on requester 0 must not hold up requester 1.
        rsp_ready = 2'b10; req_valid = 2'b01;
        set_req(0, OP_ADD, 32'd1, 32'd1, 6'd0);
        tick;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            set_req(1, OP_XOR, 32'(k + 5), 32'd3, 6'd0);
            @(negedge clk);
            chk("lit_bp_ready", req_ready, 2'b10);
            chk("lit_bp_hold_out0", rsp_out[31:0], 32'd2);
            chk("lit_bp_hold_valid0", rsp_valid[0], 1);
            if (k > 0) chk("lit_bp_out1", rsp_out[63:32], exp40[k-1]);
            tick;
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("lit_bp_out1_last", rsp_out[63:32], exp40[2]);
        tick;
        rsp_ready = 2'b11;
        tick;

        // Back-to-back issue from one requester.
        req_valid = 2'b01; rsp_ready = 2'b01;
        for (int k = 0; k < 4; k++) begin
            set_req(0, OP_ADD, 32'(k * 10), 32'd7, 6'd0);
            @(negedge clk);
            chk("lit_b2b_ready", req_ready, 2'b01);
            if (k > 0) chk("lit_b2b_out0", rsp_out[31:0], exp41[k-1]);
            tick;
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("lit_b2b_out0_last", rsp_out[31:0], exp41[3]);
        tick;

        // Mixed opcodes, valid and ready patterns; checked by the model only.
        for (int k = 0; k < 8; k++) begin
            set_req(0, 3'(k), 32'h8000_0000 ^ 32'(k * 32'h1111), 32'h0000_0F0F + 32'(k), 6'(k * 3));
            set_req(1, 3'(7 - k), 32'h0001_0000 + 32'(k * 7), 32'hFFFF_FFF0 - 32'(k), 6'(k * 5 + 1));
            req_valid = vtab[k];
            rsp_ready = rtab[k];
            tick;
        end

        // Reset with both results held.
        rsp_ready = 2'b11; req_valid = 2'b00;
        tick;
        set_req(0, OP_ADD, 32'd5, 32'd6, 6'd0);
        set_req(1, OP_OR, 32'hF0, 32'h0F, 6'd0);
        req_valid = 2'b11; rsp_ready = 2'b00;
        tick; tick;
        req_valid = 2'b00;
        @(negedge clk);
        chk("lit_mid_valid", rsp_valid, 2'b11);
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        @(negedge clk);
        chk("lit_mid_rsp_valid", rsp_valid, 2'b00);
        chk("lit_mid_rsp_out", rsp_out, 64'd0);
        chk("lit_mid_rsp_flag", rsp_flag, 4'd0);
        chk("lit_mid_ptr_grant", req_ready, 2'b01);
        tick;
        req_valid = 2'b00;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter PRIORITY_INIT, default 0, gives the requester index holding round-robin priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: requester i's operation is accepted this cycle.
REQ-006 req_x  input  64  operand x; requester i at [32i+31:32i].
REQ-007 req_y  input  64  operand y; same packing as req_x.
REQ-008 req_op  input  6  ALU opcode (ALU_OP_* encoding); requester i at [3i+2:3i].
REQ-009 req_shamt  input  12  shift amount; requester i at [6i+5:6i].
REQ-010 rsp_valid  output  2  bit i: result for requester i is held.
REQ-011 rsp_ready  input  2  bit i: requester i consumes its result.
REQ-012 rsp_out  output  64  registered ALU result; requester i at [32i+31:32i].
REQ-013 rsp_flag  output  4  registered NFlag[1:0] ({zero, overflow}); requester i at [2i+1:2i].
REQ-014 alu_x, alu_y  output  32 each  operands driven to the shared ALU.
REQ-015 alu_op  output  3  opcode driven to the ALU.
REQ-016 alu_shamt  output  6  shift amount driven to the ALU.
REQ-017 alu_flag  output  32  Flag input of the ALU; constant 32'b0.
REQ-018 alu_out  input  32  combinational ALUOut.
REQ-019 alu_nflag  input  32  combinational NFlag; only bits [1:0] used.

Function
REQ-020 eligible[i] SHALL be req_valid[i] & (~rsp_valid[i] | rsp_ready[i]).
REQ-021 At most one requester SHALL be granted per cycle; req_ready is one-hot or zero.
REQ-022 If exactly one requester is eligible, it SHALL be granted.
REQ-023 If both are eligible, the requester indicated by the priority pointer SHALL be granted.
REQ-024 On any grant to requester g, the pointer SHALL update to 1-g at the next edge; with no grant it SHALL hold.
REQ-025 req_ready SHALL be combinational from req_valid, rsp_valid, rsp_ready and the pointer; no path from alu_out.
REQ-026 alu_x/alu_y/alu_op/alu_shamt SHALL carry the granted requester's fields combinationally; with no grant they SHALL all be zero.
REQ-027 On a grant to g, the next edge SHALL set rsp_valid[g]=1, rsp_out[g]=alu_out, rsp_flag[g]=alu_nflag[1:0]; latency is exactly 1 cycle.
REQ-028 If rsp_valid[i] & rsp_ready[i] and requester i is not granted, rsp_valid[i] SHALL clear at the next edge.
REQ-029 A simultaneous consume and grant for the same i SHALL keep rsp_valid[i]=1 and load the new result, allowing one result per cycle.
REQ-030 While rsp_valid[i]=1 and rsp_ready[i]=0, rsp_out[i] and rsp_flag[i] SHALL remain stable, and requester i SHALL not be granted.
REQ-031 A stalled requester SHALL NOT block the other requester.
REQ-032 The pointer SHALL guarantee that a continuously eligible requester is granted within 2 cycles.
REQ-033 Opcodes, operands and results SHALL pass through unmodified; the arbiter does no arithmetic.

Reset
REQ-034 With rst_n=0 at an edge: rsp_valid=0, rsp_out=0, rsp_flag=0, pointer=PRIORITY_INIT.
REQ-035 During reset, req_ready SHALL be 0 and ALU drive outputs SHALL be zero.
REQ-036 A reset mid-operation SHALL discard held results without delivering them.

Verification
REQ-037 Zero flag: req0 SUB 300,300 with rsp_ready=2'b11 -> next cycle rsp_valid[0]=1, rsp_out[0]=0, rsp_flag[0]=2'b10.
REQ-038 Overflow: req1 ADD 32'h7fffffff,1 -> rsp_out[1]=32'h80000000, rsp_flag[1]=2'b01 one cycle later.
REQ-039 Contention: after reset (PRIORITY_INIT=0), both valid (req0 ADD 100,200; req1 AND 100,200) and rsp_ready=2'b11 -> cycle 0 grant 2'b01, cycle 1 grant 2'b10; rsp_out[0]=300, rsp_out[1]=64.
REQ-040 Backpressure: rsp_ready[0]=0 with rsp0 held, req0 and req1 both valid -> req_ready[0] stays 0 and rsp_out[0] is stable; req1 is granted every cycle with rsp_out[1] updating.
REQ-041 Back-to-back: req0 valid for 4 cycles, req1 idle, rsp_ready[0]=1 -> 4 grants in 4 consecutive cycles, one result per cycle.
REQ-042 Reset mid-op: rsp_valid=2'b11, then rst_n=0 for one edge -> rsp_valid=0, rsp_out=0, pointer=PRIORITY_INIT.
